// File: rtl/ltc2668_pkg.sv
// Shared definitions for the LTC2668-style SPI slave: command codes,
// legal frame lengths, channel count and the decoded frame layout.
package ltc2668_pkg;

   localparam int NUM_CHANNELS = 16;

   localparam logic [5:0] FRAME_LEN_SHORT = 6'd24;
   localparam logic [5:0] FRAME_LEN_LONG  = 6'd32;
   localparam logic [5:0] BIT_COUNT_MAX   = 6'd63;

   typedef enum logic [3:0] {
      CMD_WRITE_N              = 4'b0000,
      CMD_UPDATE_N             = 4'b0001,
      CMD_WRITE_N_UPDATE_ALL   = 4'b0010,
      CMD_WRITE_UPDATE_N       = 4'b0011,
      CMD_WRITE_ALL            = 4'b1000,
      CMD_UPDATE_ALL           = 4'b1001,
      CMD_WRITE_ALL_UPDATE_ALL = 4'b1010
   } cmdCode_t;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [3:0]  addr;
      logic [15:0] data;
   } frameFields_t;

   // The command word always lives in the low 24 bits of the shift register;
   // anything shifted in before that (the 8 pad bits of a 32-bit frame) is dropped.
   function automatic frameFields_t decodeFrame(input logic [23:0] raw);
      frameFields_t fields;
      fields.cmd  = raw[23:20];
      fields.addr = raw[19:16];
      fields.data = raw[15:0];
      return fields;
   endfunction

   // Only complete 24-bit or 32-bit transfers are accepted as commands.
   function automatic logic isLegalLength(input logic [5:0] count);
      return (count == FRAME_LEN_SHORT) || (count == FRAME_LEN_LONG);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// One asynchronous SPI pin brought into the system clock domain through a
// flop chain, with rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
   parameter int   STAGES     = 2,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic asyncIn,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] syncChain;
   logic              levelPrev;

   // The synchronizer chain resets to the pin's idle level so that leaving
   // reset never looks like an edge on the bus.
   if (STAGES == 1) begin : gSingleStage
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            syncChain <= IDLE_LEVEL;
         end else begin
            syncChain <= asyncIn;
         end
      end
   end else begin : gMultiStage
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            syncChain <= {STAGES{IDLE_LEVEL}};
         end else begin
            syncChain <= {syncChain[STAGES-2:0], asyncIn};
         end
      end
   end

   // Remember last cycle's synchronized level so edges can be detected
   // by comparing against the current one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         levelPrev <= IDLE_LEVEL;
      end else begin
         levelPrev <= syncChain[STAGES-1];
      end
   end

   assign level = syncChain[STAGES-1];
   assign rise  = level & ~levelPrev;
   assign fall  = ~level & levelPrev;

endmodule

// File: rtl/ltc2668_spi_slave.sv
// SPI mode-0 slave that decodes LTC2668-style 24/32-bit command frames into
// sixteen input/DAC register pairs, echoes the previous frame on MISO and
// offers a registered read port onto the DAC registers.
module ltc2668_spi_slave
   import ltc2668_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] RESET_CODE  = 16'h0000
) (
   input  logic        i_FPGA_clk,
   input  logic        i_FPGA_rst,
   input  logic        i_SPI_clk,
   input  logic        i_SPI_CS,
   input  logic        i_SPI_MOSI,
   output logic        o_SPI_MISO,
   input  logic [3:0]  i_rd_addr,
   output logic [15:0] o_rd_code,
   output logic        o_frame_dv,
   output logic        o_frame_err,
   output logic [3:0]  o_cmd,
   output logic [3:0]  o_addr,
   output logic [15:0] o_data,
   output logic [15:0] o_update_mask
);

   logic sckLevel;
   logic sckRise;
   logic sckFall;
   logic csLevel;
   logic csRise;
   logic csFall;
   logic mosiLevel;
   logic mosiRise;
   logic mosiFall;

   logic [31:0] shiftReg;
   logic [31:0] echoReg;
   logic [5:0]  bitCount;
   logic [23:0] lastFrame;

   logic [15:0] inputReg  [NUM_CHANNELS];
   logic [15:0] dacReg    [NUM_CHANNELS];
   logic [15:0] inputNext [NUM_CHANNELS];
   logic [15:0] dacNext   [NUM_CHANNELS];
   logic [15:0] maskNext;

   logic         commitValid;
   logic         commitErr;
   frameFields_t frame;

   logic unusedBits;

   spi_sync_edge #(
      .STAGES     (SYNC_STAGES),
      .IDLE_LEVEL (1'b0)
   ) sckSync (
      .clock   (i_FPGA_clk),
      .reset   (i_FPGA_rst),
      .asyncIn (i_SPI_clk),
      .level   (sckLevel),
      .rise    (sckRise),
      .fall    (sckFall)
   );

   spi_sync_edge #(
      .STAGES     (SYNC_STAGES),
      .IDLE_LEVEL (1'b1)
   ) csSync (
      .clock   (i_FPGA_clk),
      .reset   (i_FPGA_rst),
      .asyncIn (i_SPI_CS),
      .level   (csLevel),
      .rise    (csRise),
      .fall    (csFall)
   );

   spi_sync_edge #(
      .STAGES     (SYNC_STAGES),
      .IDLE_LEVEL (1'b0)
   ) mosiSync (
      .clock   (i_FPGA_clk),
      .reset   (i_FPGA_rst),
      .asyncIn (i_SPI_MOSI),
      .level   (mosiLevel),
      .rise    (mosiRise),
      .fall    (mosiFall)
   );

   // MOSI only needs its level and SCK only its edges; the spare flags and the
   // pad byte of the shift register are gathered here so nothing dangles.
   assign unusedBits = ^{mosiRise, mosiFall, sckLevel, shiftReg[31:24]};

   // Serial front end: a CS fall starts a new frame and preloads the echo of the
   // last good frame; while CS is low, SCK rises shift MOSI in and SCK falls
   // advance the echo. CS events take priority over any coincident SCK edge.
   always_ff @(posedge i_FPGA_clk or posedge i_FPGA_rst) begin
      if (i_FPGA_rst) begin
         shiftReg <= '0;
         bitCount <= '0;
         echoReg  <= '0;
      end else if (csFall) begin
         bitCount <= '0;
         echoReg  <= {8'h00, lastFrame};
      end else if (!csLevel && !csRise) begin
         if (sckRise) begin
            shiftReg <= {shiftReg[30:0], mosiLevel};
            if (bitCount != BIT_COUNT_MAX) begin
               bitCount <= bitCount + 6'd1;
            end
         end
         if (sckFall) begin
            echoReg <= {echoReg[30:0], 1'b0};
         end
      end
   end

   // MISO is driven only while the synchronized chip select is low.
   assign o_SPI_MISO = ~csLevel & echoReg[31];

   // At the end of a frame, decide whether it is a command to commit, an error
   // (wrong bit count) or an empty select to be ignored entirely.
   always_comb begin
      commitValid = 1'b0;
      commitErr   = 1'b0;
      frame       = decodeFrame(shiftReg[23:0]);
      if (csRise) begin
         if (isLegalLength(bitCount)) begin
            commitValid = 1'b1;
         end else if (bitCount != 6'd0) begin
            commitErr = 1'b1;
         end
      end
   end

   // Work out the next contents of both register banks for a committed command.
   // Input writes are applied before any update so an update-all in the same
   // command picks up the freshly written value.
   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         inputNext[i] = inputReg[i];
         dacNext[i]   = dacReg[i];
      end
      maskNext = '0;
      if (commitValid) begin
         case (frame.cmd)
            CMD_WRITE_N: begin
               inputNext[frame.addr] = frame.data;
            end
            CMD_UPDATE_N: begin
               dacNext[frame.addr]  = inputReg[frame.addr];
               maskNext[frame.addr] = 1'b1;
            end
            CMD_WRITE_UPDATE_N: begin
               inputNext[frame.addr] = frame.data;
               dacNext[frame.addr]   = frame.data;
               maskNext[frame.addr]  = 1'b1;
            end
            CMD_WRITE_N_UPDATE_ALL: begin
               inputNext[frame.addr] = frame.data;
               for (int i = 0; i < NUM_CHANNELS; i++) begin
                  dacNext[i] = inputNext[i];
               end
               maskNext = '1;
            end
            CMD_WRITE_ALL: begin
               for (int i = 0; i < NUM_CHANNELS; i++) begin
                  inputNext[i] = frame.data;
               end
            end
            CMD_UPDATE_ALL: begin
               for (int i = 0; i < NUM_CHANNELS; i++) begin
                  dacNext[i] = inputReg[i];
               end
               maskNext = '1;
            end
            CMD_WRITE_ALL_UPDATE_ALL: begin
               for (int i = 0; i < NUM_CHANNELS; i++) begin
                  inputNext[i] = frame.data;
                  dacNext[i]   = frame.data;
               end
               maskNext = '1;
            end
            default: begin
            end
         endcase
      end
   end

   // Register banks take their next values every cycle; outside a commit the
   // next values are simply the current ones.
   always_ff @(posedge i_FPGA_clk or posedge i_FPGA_rst) begin
      if (i_FPGA_rst) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            inputReg[i] <= RESET_CODE;
            dacReg[i]   <= RESET_CODE;
         end
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            inputReg[i] <= inputNext[i];
            dacReg[i]   <= dacNext[i];
         end
      end
   end

   // Frame status: one-cycle pulses for commit/error and the update mask, plus
   // the decoded fields and echo source held from one good frame to the next.
   always_ff @(posedge i_FPGA_clk or posedge i_FPGA_rst) begin
      if (i_FPGA_rst) begin
         o_frame_dv    <= 1'b0;
         o_frame_err   <= 1'b0;
         o_update_mask <= '0;
         o_cmd         <= '0;
         o_addr        <= '0;
         o_data        <= '0;
         lastFrame     <= '0;
      end else begin
         o_frame_dv    <= commitValid;
         o_frame_err   <= commitErr;
         o_update_mask <= maskNext;
         if (commitValid) begin
            o_cmd     <= frame.cmd;
            o_addr    <= frame.addr;
            o_data    <= frame.data;
            lastFrame <= shiftReg[23:0];
         end
      end
   end

   // Registered read port; a DAC write in the same cycle shows up one read later.
   always_ff @(posedge i_FPGA_clk or posedge i_FPGA_rst) begin
      if (i_FPGA_rst) begin
         o_rd_code <= '0;
      end else begin
         o_rd_code <= dacReg[i_rd_addr];
      end
   end

endmodule

// File: tb/tb_ltc2668_spi_slave.sv
// Directed bench for the LTC2668 SPI slave: drives SPI frames, predicts the
// commit/error pulses through a scoreboard queue and mirrors the register
// banks in a small behavioural model checked through the read port.
`timescale 1ns/1ps
module tb_ltc2668_spi_slave;

   typedef struct {
      bit          isErr;
      logic [3:0]  cmd;
      logic [3:0]  addr;
      logic [15:0] data;
      logic [15:0] mask;
   } sbEntry_t;

   logic        fpgaClk;
   logic        fpgaRst;
   logic        spiSck;
   logic        spiCs;
   logic        spiMosi;
   logic        spiMiso;
   logic [3:0]  rdAddr;
   logic [15:0] rdCode;
   logic        frameDv;
   logic        frameErr;
   logic [3:0]  cmdOut;
   logic [3:0]  addrOut;
   logic [15:0] dataOut;
   logic [15:0] updateMask;

   int checkCount = 0;
   int failCount  = 0;

   sbEntry_t    sbQueue[$];
   sbEntry_t    expEntry;
   logic [15:0] modelInput [16];
   logic [15:0] modelDac   [16];
   logic [23:0] modelLast;

   ltc2668_spi_slave dut (
      .i_FPGA_clk    (fpgaClk),
      .i_FPGA_rst    (fpgaRst),
      .i_SPI_clk     (spiSck),
      .i_SPI_CS      (spiCs),
      .i_SPI_MOSI    (spiMosi),
      .o_SPI_MISO    (spiMiso),
      .i_rd_addr     (rdAddr),
      .o_rd_code     (rdCode),
      .o_frame_dv    (frameDv),
      .o_frame_err   (frameErr),
      .o_cmd         (cmdOut),
      .o_addr        (addrOut),
      .o_data        (dataOut),
      .o_update_mask (updateMask)
   );

   // 100 MHz system clock; SPI runs at 10 MHz so the 4x ratio holds comfortably.
   initial begin
      fpgaClk = 1'b0;
      forever #5 fpgaClk = ~fpgaClk;
   end

   // Hard stop in case anything upstream stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL globalTimeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 16; i++) begin
         modelInput[i] = 16'h0000;
         modelDac[i]   = 16'h0000;
      end
      modelLast = 24'h000000;
   endtask

   task automatic modelCommit(input logic [23:0] raw, output logic [15:0] mask);
      logic [3:0]  c;
      logic [3:0]  a;
      logic [15:0] d;
      c    = raw[23:20];
      a    = raw[19:16];
      d    = raw[15:0];
      mask = 16'h0000;
      case (c)
         4'h0: modelInput[a] = d;
         4'h1: begin
            modelDac[a] = modelInput[a];
            mask[a]     = 1'b1;
         end
         4'h2: begin
            modelInput[a] = d;
            for (int i = 0; i < 16; i++) modelDac[i] = modelInput[i];
            mask = 16'hFFFF;
         end
         4'h3: begin
            modelInput[a] = d;
            modelDac[a]   = d;
            mask[a]       = 1'b1;
         end
         4'h8: for (int i = 0; i < 16; i++) modelInput[i] = d;
         4'h9: begin
            for (int i = 0; i < 16; i++) modelDac[i] = modelInput[i];
            mask = 16'hFFFF;
         end
         4'hA: begin
            for (int i = 0; i < 16; i++) begin
               modelInput[i] = d;
               modelDac[i]   = d;
            end
            mask = 16'hFFFF;
         end
         default: ;
      endcase
   endtask

   task automatic shiftBits(input logic [31:0] frame, input int nBits, output logic [31:0] misoBits);
      misoBits = 32'h0;
      for (int i = nBits - 1; i >= 0; i--) begin
         spiMosi = frame[i % 32];
         #50;
         misoBits = {misoBits[30:0], spiMiso};
         spiSck = 1'b1;
         #50;
         spiSck = 1'b0;
      end
   endtask

   task automatic waitDrain();
      for (int c = 0; c < 40; c++) begin
         if (sbQueue.size() == 0) break;
         @(negedge fpgaClk);
      end
      checkOutput("scoreboardDrain", 32'(sbQueue.size()), 32'h0);
      sbQueue.delete();
   endtask

   // One complete frame; optionally the final CS rise coincides with an extra SCK rise.
   task automatic applyStimulus(input logic [31:0] frame, input int nBits, input bit sckWithCs);
      logic [31:0] misoBits;
      logic [31:0] expEcho;
      logic [15:0] expMask;
      sbEntry_t    entry;
      expEcho = {8'h00, modelLast};
      if (nBits == 24 || nBits == 32) begin
         modelCommit(frame[23:0], expMask);
         entry.isErr = 1'b0;
         entry.cmd   = frame[23:20];
         entry.addr  = frame[19:16];
         entry.data  = frame[15:0];
         entry.mask  = expMask;
         sbQueue.push_back(entry);
         modelLast = frame[23:0];
      end else if (nBits != 0) begin
         entry.isErr = 1'b1;
         entry.cmd   = 4'h0;
         entry.addr  = 4'h0;
         entry.data  = 16'h0;
         entry.mask  = 16'h0;
         sbQueue.push_back(entry);
      end
      spiCs = 1'b0;
      #100;
      shiftBits(frame, nBits, misoBits);
      if (sckWithCs) begin
         spiMosi = 1'b1;
         #50;
         spiSck = 1'b1;
         spiCs  = 1'b1;
         #50;
         spiSck = 1'b0;
      end else begin
         #100;
         spiCs = 1'b1;
      end
      #100;
      checkOutput("misoIdle", 32'(spiMiso), 32'h0);
      if (nBits >= 1 && nBits <= 32) begin
         checkOutput($sformatf("misoEcho_%06h", frame[23:0]), misoBits, expEcho >> (32 - nBits));
      end
      waitDrain();
   endtask

   task automatic checkAllChannels(input string tag);
      @(negedge fpgaClk);
      for (int ch = 0; ch < 16; ch++) begin
         rdAddr = 4'(ch);
         @(negedge fpgaClk);
         checkOutput($sformatf("%s_dac%0d", tag, ch), 32'(rdCode), 32'(modelDac[ch]));
      end
   endtask

   task automatic checkHeld(input string tag);
      checkOutput({tag, "_cmd"},  32'(cmdOut),  32'(modelLast[23:20]));
      checkOutput({tag, "_addr"}, 32'(addrOut), 32'(modelLast[19:16]));
      checkOutput({tag, "_data"}, 32'(dataOut), 32'(modelLast[15:0]));
   endtask

   // Scoreboard consumer: every commit/error pulse must match the oldest
   // prediction, and the update mask must never pulse on its own.
   always @(negedge fpgaClk) begin
      if (!fpgaRst) begin
         if (frameDv || frameErr) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpectedPulse", 32'({frameDv, frameErr}), 32'h0);
            end else begin
               expEntry = sbQueue.pop_front();
               checkOutput("pulseKind", 32'({frameDv, frameErr}), 32'(expEntry.isErr ? 2'b01 : 2'b10));
               checkOutput("pulseMask", 32'(updateMask), 32'(expEntry.mask));
               if (!expEntry.isErr) begin
                  checkOutput("commitCmd",  32'(cmdOut),  32'(expEntry.cmd));
                  checkOutput("commitAddr", 32'(addrOut), 32'(expEntry.addr));
                  checkOutput("commitData", 32'(dataOut), 32'(expEntry.data));
               end
            end
         end else if (updateMask != 16'h0) begin
            checkOutput("strayMask", 32'(updateMask), 32'h0);
         end
      end
   end

   // Directed sequence covering each command, frame-length handling, the MISO
   // echo, coincident CS/SCK edges and a reset in the middle of a frame.
   initial begin
      logic [31:0] partialMiso;
      spiSck  = 1'b0;
      spiCs   = 1'b1;
      spiMosi = 1'b0;
      rdAddr  = 4'h0;
      fpgaRst = 1'b1;
      modelReset();
      repeat (5) @(negedge fpgaClk);
      checkOutput("resetDv",     32'(frameDv),    32'h0);
      checkOutput("resetErr",    32'(frameErr),   32'h0);
      checkOutput("resetMask",   32'(updateMask), 32'h0);
      checkOutput("resetRdCode", 32'(rdCode),     32'h0);
      checkOutput("resetMiso",   32'(spiMiso),    32'h0);
      checkHeld("reset");
      fpgaRst = 1'b0;
      repeat (5) @(negedge fpgaClk);
      checkAllChannels("resetBank");

      $display("[TB] write-and-update single channel");
      applyStimulus(32'h0035ABCD, 24, 1'b0);
      checkAllChannels("wu5");

      $display("[TB] 32-bit write then update-all");
      applyStimulus(32'hFF021234, 32, 1'b0);
      checkAllChannels("write2");
      applyStimulus(32'h00900000, 24, 1'b0);
      checkAllChannels("updAll");

      $display("[TB] illegal 20-bit frame");
      applyStimulus(32'h000ABCDE, 20, 1'b0);
      checkAllChannels("err20");
      checkHeld("err20");

      $display("[TB] MISO echo of previous frame");
      applyStimulus(32'h00315555, 24, 1'b0);
      applyStimulus(32'hAB0A7777, 32, 1'b0);
      checkAllChannels("echo");

      $display("[TB] remaining command codes");
      applyStimulus(32'h00241111, 24, 1'b0);
      checkAllChannels("wrUpdAll");
      applyStimulus(32'h00802222, 24, 1'b0);
      checkAllChannels("wrAll");
      applyStimulus(32'h00A03333, 24, 1'b0);
      checkAllChannels("wrAllUpdAll");
      applyStimulus(32'h00074444, 24, 1'b0);
      applyStimulus(32'h00170000, 24, 1'b0);
      checkAllChannels("upd7");
      applyStimulus(32'h00539999, 24, 1'b0);
      checkAllChannels("unknownCmd");

      $display("[TB] empty, long and saturating frames");
      applyStimulus(32'h00000000, 0, 1'b0);
      checkHeld("empty");
      applyStimulus(32'h12345678, 88, 1'b0);
      applyStimulus(32'h00C3FFFF, 40, 1'b0);
      checkAllChannels("longErr");
      checkHeld("longErr");

      $display("[TB] CS rise coincident with SCK rise");
      applyStimulus(32'h0036BEEF, 24, 1'b1);
      checkAllChannels("coincident");

      $display("[TB] SCK toggling with CS high");
      for (int i = 0; i < 5; i++) begin
         #50 spiSck = 1'b1;
         #50 spiSck = 1'b0;
      end
      applyStimulus(32'h00381357, 24, 1'b0);
      checkAllChannels("sckIdle");

      $display("[TB] reset in the middle of a frame");
      spiCs = 1'b0;
      #100;
      shiftBits(32'h003F0F0F, 12, partialMiso);
      fpgaRst = 1'b1;
      #100;
      spiCs = 1'b1;
      #100;
      checkOutput("midResetDv",   32'(frameDv),    32'h0);
      checkOutput("midResetMask", 32'(updateMask), 32'h0);
      checkOutput("midResetMiso", 32'(spiMiso),    32'h0);
      modelReset();
      checkHeld("midReset");
      @(negedge fpgaClk);
      fpgaRst = 1'b0;
      repeat (10) @(negedge fpgaClk);
      checkOutput("postResetQueue", 32'(sbQueue.size()), 32'h0);
      checkAllChannels("postReset");
      applyStimulus(32'h00322468, 24, 1'b0);
      checkAllChannels("cleanFrame");
      checkHeld("cleanFrame");

      repeat (5) @(negedge fpgaClk);
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
